// File: rtl/mem_write_arbiter_if.sv
// Write-path bundle shared by the ingress write controllers, the write arbiter and the
// packet-buffer SRAM write port.
interface mem_write_arbiter_if #(
  parameter int N_PORTS    = 4,
  parameter int ADDR_W     = 9,
  parameter int BLOCK_BITS = 512,
  parameter int CNT_W      = 16,
  parameter int IDX_W      = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
);
  logic [N_PORTS-1:0]            req_i;
  logic [N_PORTS-1:0]            rdy_o;
  logic [N_PORTS-1:0]            we_i;
  logic [N_PORTS*ADDR_W-1:0]     addr_i;
  logic [N_PORTS*BLOCK_BITS-1:0] wdata_i;
  logic                          sram_we_o;
  logic [ADDR_W-1:0]             sram_addr_o;
  logic [BLOCK_BITS-1:0]         sram_wdata_o;
  logic                          sram_ready_i;
  logic [IDX_W-1:0]              grant_idx_o;
  logic                          busy_o;
  logic                          err_o;
  logic [CNT_W-1:0]              write_cnt_o;

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, sram_ready_i,
    output rdy_o, sram_we_o, sram_addr_o, sram_wdata_o, grant_idx_o, busy_o, err_o, write_cnt_o
  );

  modport master (
    output req_i, we_i, addr_i, wdata_i, sram_ready_i,
    input  rdy_o, sram_we_o, sram_addr_o, sram_wdata_o, grant_idx_o, busy_o, err_o, write_cnt_o
  );
endinterface

// File: rtl/mem_write_arbiter.sv
// Round-robin arbiter sharing the single packet-buffer SRAM write port among the ingress
// write controllers; one block write in flight at a time, all outputs registered.
module mem_write_arbiter #(
  parameter int N_PORTS    = 4,
  parameter int ADDR_W     = 9,
  parameter int BLOCK_BITS = 512,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_write_arbiter_if.slave bus
);
  localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_ISSUE   = 2'd3
  } state_t;

  state_t                  state_r, state_s;
  logic [IDX_W-1:0]        rr_ptr_r, rr_ptr_s;
  logic [IDX_W-1:0]        grant_idx_r, grant_idx_s;
  logic [N_PORTS-1:0]      rdy_r, rdy_s;
  logic                    sram_we_r, sram_we_s;
  logic [ADDR_W-1:0]       sram_addr_r, sram_addr_s;
  logic [BLOCK_BITS-1:0]   sram_wdata_r, sram_wdata_s;
  logic                    busy_r, busy_s;
  logic                    err_r, err_s;
  logic [CNT_W-1:0]        cnt_r, cnt_s;

  logic                    pick_found_s, hit_s;
  logic [IDX_W-1:0]        pick_idx_s, cand_s;
  logic [ADDR_W-1:0]       addr_arr_s  [N_PORTS];
  logic [BLOCK_BITS-1:0]   wdata_arr_s [N_PORTS];
  logic                    sel_we_s;

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
    if (idx == IDX_W'(N_PORTS - 1)) begin
      next_ptr = {IDX_W{1'b0}};
    end else begin
      next_ptr = idx + IDX_W'(1);
    end
  endfunction

  // Round-robin search: first requester at or after rr_ptr, wrapping modulo N_PORTS.
  always_comb begin
    pick_found_s = 1'b0;
    pick_idx_s   = {IDX_W{1'b0}};
    cand_s       = {IDX_W{1'b0}};
    hit_s        = 1'b0;
    for (int i = 0; i < N_PORTS; i++) begin
      cand_s       = IDX_W'((int'(rr_ptr_r) + i) % N_PORTS);
      hit_s        = !pick_found_s && bus.req_i[cand_s];
      pick_idx_s   = hit_s ? cand_s : pick_idx_s;
      pick_found_s = pick_found_s | hit_s;
    end
  end

  // Unpack the per-port address and data slices so the granted one can be indexed.
  always_comb begin
    for (int k = 0; k < N_PORTS; k++) begin
      addr_arr_s[k]  = bus.addr_i[k*ADDR_W +: ADDR_W];
      wdata_arr_s[k] = bus.wdata_i[k*BLOCK_BITS +: BLOCK_BITS];
    end
    sel_we_s = bus.we_i[grant_idx_r];
  end

  // Next-state and next-output logic; every output is computed here and registered below.
  always_comb begin
    state_s      = state_r;
    rr_ptr_s     = rr_ptr_r;
    grant_idx_s  = grant_idx_r;
    rdy_s        = {N_PORTS{1'b0}};
    sram_we_s    = sram_we_r;
    sram_addr_s  = sram_addr_r;
    sram_wdata_s = sram_wdata_r;
    err_s        = err_r;
    cnt_s        = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (pick_found_s) begin
          grant_idx_s = pick_idx_s;
          rdy_s       = {{(N_PORTS-1){1'b0}}, 1'b1} << pick_idx_s;
          state_s     = ST_GRANT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_GRANT: begin
        state_s = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (sel_we_s) begin
          sram_addr_s  = addr_arr_s[grant_idx_r];
          sram_wdata_s = wdata_arr_s[grant_idx_r];
          sram_we_s    = 1'b1;
          state_s      = ST_ISSUE;
        end else begin
          // Granted controller never strobed: flag it and move the pointer past it.
          err_s    = 1'b1;
          rr_ptr_s = next_ptr(grant_idx_r);
          state_s  = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (bus.sram_ready_i) begin
          sram_we_s = 1'b0;
          cnt_s     = (cnt_r == {CNT_W{1'b1}}) ? cnt_r : cnt_r + CNT_W'(1);
          rr_ptr_s  = next_ptr(grant_idx_r);
          state_s   = ST_IDLE;
        end else begin
          state_s = ST_ISSUE;
        end
      end
      default: begin
        sram_we_s = 1'b0;
        state_s   = ST_IDLE;
      end
    endcase
    busy_s = (state_s != ST_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      rr_ptr_r     <= {IDX_W{1'b0}};
      grant_idx_r  <= {IDX_W{1'b0}};
      rdy_r        <= {N_PORTS{1'b0}};
      sram_we_r    <= 1'b0;
      sram_addr_r  <= {ADDR_W{1'b0}};
      sram_wdata_r <= {BLOCK_BITS{1'b0}};
      busy_r       <= 1'b0;
      err_r        <= 1'b0;
      cnt_r        <= {CNT_W{1'b0}};
    end else begin
      state_r      <= state_s;
      rr_ptr_r     <= rr_ptr_s;
      grant_idx_r  <= grant_idx_s;
      rdy_r        <= rdy_s;
      sram_we_r    <= sram_we_s;
      sram_addr_r  <= sram_addr_s;
      sram_wdata_r <= sram_wdata_s;
      busy_r       <= busy_s;
      err_r        <= err_s;
      cnt_r        <= cnt_s;
    end
  end

  assign bus.rdy_o        = rdy_r;
  assign bus.sram_we_o    = sram_we_r;
  assign bus.sram_addr_o  = sram_addr_r;
  assign bus.sram_wdata_o = sram_wdata_r;
  assign bus.grant_idx_o  = grant_idx_r;
  assign bus.busy_o       = busy_r;
  assign bus.err_o        = err_r;
  assign bus.write_cnt_o  = cnt_r;
endmodule
